// File: rtl/dcache_2way_if.sv
// CPU-side load/store handshake and memory-side block handshake for dcache_2way.
interface dcache_2way_if #(
    parameter int ADDR_W      = 8,
    parameter int BLOCK_BYTES = 4
);
    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int BLK_W = 8 * BLOCK_BYTES;

    logic                    read;
    logic                    write;
    logic [ADDR_W-1:0]       ADDRESS;
    logic [7:0]              WRITEDATA;
    logic [7:0]              READDATA;
    logic                    busywait;
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_W-OFF_W-1:0] mem_address;
    logic [BLK_W-1:0]        mem_writedata;
    logic [BLK_W-1:0]        mem_readdata;
    logic                    mem_busywait;

    // Cache view of both handshakes.
    modport slave (
        input  read, write, ADDRESS, WRITEDATA, mem_readdata, mem_busywait,
        output READDATA, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    // CPU and memory view (the environment driving the cache).
    modport master (
        output read, write, ADDRESS, WRITEDATA, mem_readdata, mem_busywait,
        input  READDATA, busywait, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/dcache_2way.sv
// Two-way set-associative write-back/write-allocate data cache with per-set LRU.
// Optional hit/miss statistics are built when DCACHE_STATS_EN is defined.
module dcache_2way #(
    parameter int ADDR_W      = 8,
    parameter int SETS        = 4,
    parameter int BLOCK_BYTES = 4
) (
    input  logic          clock,
    input  logic          reset,
    dcache_2way_if.slave  bus,
    output logic [15:0]   hit_count,
    output logic [15:0]   miss_count
);
    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W = 8 * BLOCK_BYTES;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2,
        S_REFILL    = 2'd3
    } state_t;

    state_t                              state_q, state_d;
    logic [SETS-1:0][1:0]                valid_q, valid_d;
    logic [SETS-1:0][1:0]                dirty_q, dirty_d;
    logic [SETS-1:0][1:0][TAG_W-1:0]     tag_q, tag_d;
    logic [SETS-1:0][1:0][BLK_W-1:0]     data_q, data_d;
    logic [SETS-1:0]                     lru_q, lru_d;
    logic                                victim_q, victim_d;

    logic [TAG_W-1:0] addr_tag_s;
    logic [IDX_W-1:0] addr_idx_s;
    logic [OFF_W-1:0] addr_off_s;
    logic             req_s;
    logic             hit0_s;
    logic             hit1_s;
    logic             hit_s;
    logic             hit_way_s;
    logic             victim_sel_s;
    logic             idle_hit_s;
    logic             idle_miss_s;

    assign addr_tag_s   = bus.ADDRESS[ADDR_W-1 -: TAG_W];
    assign addr_idx_s   = bus.ADDRESS[OFF_W +: IDX_W];
    assign addr_off_s   = bus.ADDRESS[OFF_W-1:0];
    assign req_s        = bus.read | bus.write;
    assign hit0_s       = valid_q[addr_idx_s][0] && (tag_q[addr_idx_s][0] == addr_tag_s);
    assign hit1_s       = valid_q[addr_idx_s][1] && (tag_q[addr_idx_s][1] == addr_tag_s);
    assign hit_s        = hit0_s | hit1_s;
    assign hit_way_s    = hit0_s ? 1'b0 : 1'b1;
    assign victim_sel_s = !valid_q[addr_idx_s][0] ? 1'b0 :
                          !valid_q[addr_idx_s][1] ? 1'b1 : lru_q[addr_idx_s];
    assign idle_hit_s   = (state_q == S_IDLE) && req_s && hit_s;
    assign idle_miss_s  = (state_q == S_IDLE) && req_s && !hit_s;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (idle_miss_s) begin
                    if (valid_q[addr_idx_s][victim_sel_s] && dirty_q[addr_idx_s][victim_sel_s]) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITEBACK: begin
                if (!bus.mem_busywait) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_FETCH: begin
                if (!bus.mem_busywait) begin
                    state_d = S_REFILL;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_REFILL: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode: memory requests come straight from the registered state.
    always_comb begin
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_address   = '0;
        bus.mem_writedata = '0;
        case (state_q)
            S_WRITEBACK: begin
                bus.mem_write     = 1'b1;
                bus.mem_address   = {tag_q[addr_idx_s][victim_q], addr_idx_s};
                bus.mem_writedata = data_q[addr_idx_s][victim_q];
            end
            S_FETCH: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = {addr_tag_s, addr_idx_s};
            end
            default: begin
                bus.mem_read  = 1'b0;
                bus.mem_write = 1'b0;
            end
        endcase
        bus.busywait = req_s && !((state_q == S_IDLE) && hit_s);
        if (hit_s) begin
            bus.READDATA = data_q[addr_idx_s][hit_way_s][{addr_off_s, 3'b000} +: 8];
        end else begin
            bus.READDATA = 8'h00;
        end
    end

    // Array updates: store merge and LRU on hits, block install at fetch completion.
    always_comb begin
        valid_d  = valid_q;
        dirty_d  = dirty_q;
        tag_d    = tag_q;
        data_d   = data_q;
        lru_d    = lru_q;
        victim_d = victim_q;
        if (idle_miss_s) begin
            victim_d = victim_sel_s;
        end else begin
            victim_d = victim_q;
        end
        if (idle_hit_s) begin
            lru_d[addr_idx_s] = ~hit_way_s;
            if (bus.write) begin
                data_d[addr_idx_s][hit_way_s][{addr_off_s, 3'b000} +: 8] = bus.WRITEDATA;
                dirty_d[addr_idx_s][hit_way_s] = 1'b1;
            end else begin
                dirty_d[addr_idx_s][hit_way_s] = dirty_q[addr_idx_s][hit_way_s];
            end
        end else if ((state_q == S_FETCH) && !bus.mem_busywait) begin
            data_d[addr_idx_s][victim_q]  = bus.mem_readdata;
            tag_d[addr_idx_s][victim_q]   = addr_tag_s;
            valid_d[addr_idx_s][victim_q] = 1'b1;
            dirty_d[addr_idx_s][victim_q] = 1'b0;
            lru_d[addr_idx_s]             = ~victim_q;
        end else begin
            lru_d = lru_q;
        end
    end

    // Cache array registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            dirty_q  <= '0;
            tag_q    <= '0;
            data_q   <= '0;
            lru_q    <= '0;
            victim_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            tag_q    <= tag_d;
            data_q   <= data_d;
            lru_q    <= lru_d;
            victim_q <= victim_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic        miss_pend_q, miss_pend_d;

    // The hit that finishes a miss is not counted as a hit.
    always_comb begin
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        miss_pend_d = miss_pend_q;
        if (idle_hit_s) begin
            miss_pend_d = 1'b0;
            if (!miss_pend_q && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
                hit_cnt_d = hit_cnt_q;
            end
        end else if (idle_miss_s) begin
            miss_pend_d = 1'b1;
            if (miss_cnt_q != 16'hFFFF) begin
                miss_cnt_d = miss_cnt_q + 16'd1;
            end else begin
                miss_cnt_d = miss_cnt_q;
            end
        end else begin
            miss_pend_d = miss_pend_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_cnt_q   <= 16'd0;
            miss_cnt_q  <= 16'd0;
            miss_pend_q <= 1'b0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            miss_pend_q <= miss_pend_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule
